// File: rtl/bit_serial_adder.sv
// ---------------------------------------------------------------------------
// bit_serial_adder
//   Adds two WIDTH-bit unsigned operands plus a carry-in, LSB first, one bit
//   per clock through a single 1-bit full_adder stage. The carry between bit
//   positions is held in a flip-flop. The result is {cout, sum} =
//   in_a + in_b + cin, modulo 2^(WIDTH+1).
//
//   Timing: a start accepted at edge T gives busy=1 for cycles T+1..T+WIDTH
//   and a one-cycle done pulse in cycle T+WIDTH+1. A start seen during the
//   done cycle is accepted immediately (back-to-back operation).
//
// Ports
//   sys_clk    in   1      system clock, rising edge
//   sys_rst_n  in   1      asynchronous active-low reset
//   start      in   1      add request, sampled only in IDLE or DONE
//   in_a       in   WIDTH  operand A, captured on an accepted start
//   in_b       in   WIDTH  operand B, captured on an accepted start
//   cin        in   1      carry-in, captured on an accepted start
//   busy       out  1      high while bits are being added
//   done       out  1      one-cycle pulse, sum/cout valid from this cycle
//   sum        out  WIDTH  result, held until the next done
//   cout       out  1      final carry-out, held until the next done
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

// Single-bit full adder stage used by the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum_bit,
    output logic carry_out
);
    assign sum_bit   = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             accept;

    logic [WIDTH-1:0] a_sr_reg;
    logic [WIDTH-1:0] b_sr_reg;
    logic [WIDTH-1:0] sum_sr_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;

    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;
    logic [WIDTH-1:0] sum_sr_next;

    full_adder u_fa (
        .a         (a_sr_reg[0]),
        .b         (b_sr_reg[0]),
        .carry_in  (carry_reg),
        .sum_bit   (fa_sum),
        .carry_out (fa_carry)
    );

    // New sum bit enters from the MSB side; after WIDTH shifts bit 0 of the
    // result has travelled down to sum_sr[0].
    assign sum_sr_next = (sum_sr_reg >> 1) | ({{(WIDTH-1){1'b0}}, fa_sum} << (WIDTH-1));
    assign last_bit    = (cnt_reg == CW'(WIDTH-1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and accept decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next = IDLE;
        accept     = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                // DONE accepts a new start just like IDLE so a held start
                // streams one add every WIDTH+1 cycles.
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                state_next = last_bit ? DONE : RUN;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Serial datapath
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            a_sr_reg   <= '0;
            b_sr_reg   <= '0;
            sum_sr_reg <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            sum_reg    <= '0;
            cout_reg   <= 1'b0;
        end else if (accept) begin
            a_sr_reg  <= in_a;
            b_sr_reg  <= in_b;
            carry_reg <= cin;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            a_sr_reg   <= a_sr_reg >> 1;
            b_sr_reg   <= b_sr_reg >> 1;
            carry_reg  <= fa_carry;
            sum_sr_reg <= sum_sr_next;
            cnt_reg    <= cnt_reg + 1'b1;
            // Publish the finished result on the same edge that enters DONE,
            // so sum/cout stay stable through IDLE and the next RUN.
            if (last_bit) begin
                sum_reg  <= sum_sr_next;
                cout_reg <= fa_carry;
            end
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_bit_serial_adder.sv
`timescale 1ns/1ps

module tb_bit_serial_adder;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;

    // 8-bit instance
    logic        start = 1'b0;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        cin = 1'b0;
    logic        busy;
    logic        done;
    logic [7:0]  sum;
    logic        cout;

    // 13-bit instance
    logic        start13 = 1'b0;
    logic [12:0] in_a13 = '0;
    logic [12:0] in_b13 = '0;
    logic        cin13 = 1'b0;
    logic        busy13;
    logic        done13;
    logic [12:0] sum13;
    logic        cout13;

    int total = 0;
    int bad   = 0;

    always #5 sys_clk = ~sys_clk;

    bit_serial_adder #(.WIDTH(8)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .in_a      (in_a),
        .in_b      (in_b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout)
    );

    bit_serial_adder #(.WIDTH(13)) dut13 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start13),
        .in_a      (in_a13),
        .in_b      (in_b13),
        .cin       (cin13),
        .busy      (busy13),
        .done      (done13),
        .sum       (sum13),
        .cout      (cout13)
    );

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic test_reset;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b, need 0 0 00 0",
                     busy, done, sum, cout);
        end else
            $display("reset_state ok");
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_quiet cycle %0d: done=%b busy=%b, need 0 0", i, done, busy);
            end
        end
        $display("idle_quiet checked 20 cycles");
    endtask

    // One add on the 8-bit instance with full latency check; starts from IDLE.
    task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic [7:0] exp_sum, input logic exp_cout, input string tag);
        in_a  = a;
        in_b  = b;
        cin   = ci;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL %s run cycle %0d: busy=%b done=%b, need 1 0", tag, i, busy, done);
            end
            @(negedge sys_clk);
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s done_cycle: done=%b busy=%b, need 1 0", tag, done, busy);
        end
        total++;
        if (sum !== exp_sum || cout !== exp_cout) begin
            bad++;
            $display("FAIL %s result: sum=%h cout=%b, need sum=%h cout=%b",
                     tag, sum, cout, exp_sum, exp_cout);
        end else
            $display("%s: %h + %h + %b -> sum=%h cout=%b", tag, a, b, ci, sum, cout);
        @(negedge sys_clk);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL %s done_pulse_width: done=%b, need 0", tag, done);
        end
    endtask

    task automatic test_basic;
        do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01");
    endtask

    task automatic test_vectors;
        do_add(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "add_a5_5a_c1");
        do_add(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "add_12_34");
        do_add(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "add_zero");
        do_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_max");
    endtask

    task automatic test_ignore_start;
        int dones;
        in_a  = 8'h10;
        in_b  = 8'h20;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) begin
                in_a  = 8'hFF;
                in_b  = 8'hFF;
                cin   = 1'b1;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge sys_clk);
        end
        start = 1'b0;
        total++;
        if (done !== 1'b1 || sum !== 8'h30 || cout !== 1'b0) begin
            bad++;
            $display("FAIL ignore_start result: done=%b sum=%h cout=%b, need 1 30 0",
                     done, sum, cout);
        end else
            $display("ignore_start: sum=%h cout=%b", sum, cout);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge sys_clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        total++;
        if (dones != 0 || sum !== 8'h30) begin
            bad++;
            $display("FAIL ignore_start extra_activity: active_cycles=%0d sum=%h, need 0 and 30",
                     dones, sum);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic       vc [3];
        logic [7:0] es [3];
        logic       ec [3];
        va[0] = 8'h01; vb[0] = 8'h02; vc[0] = 1'b0; es[0] = 8'h03; ec[0] = 1'b0;
        va[1] = 8'h80; vb[1] = 8'h80; vc[1] = 1'b1; es[1] = 8'h01; ec[1] = 1'b1;
        va[2] = 8'h7F; vb[2] = 8'h0F; vc[2] = 1'b0; es[2] = 8'h8E; ec[2] = 1'b0;
        in_a  = va[0];
        in_b  = vb[0];
        cin   = vc[0];
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 1; i <= 8; i++) begin
                @(negedge sys_clk);
                if (i == 2) begin
                    in_a = 8'hCC;
                    in_b = 8'h33;
                    cin  = ~cin;
                end
                total++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b add%0d run cycle %0d: busy=%b done=%b, need 1 0",
                             k, i, busy, done);
                end
            end
            @(negedge sys_clk);
            total++;
            if (done !== 1'b1 || sum !== es[k] || cout !== ec[k]) begin
                bad++;
                $display("FAIL b2b add%0d: done=%b sum=%h cout=%b, need 1 %h %b",
                         k, done, sum, cout, es[k], ec[k]);
            end else
                $display("b2b add%0d: sum=%h cout=%b", k, sum, cout);
            if (k < 2) begin
                in_a = va[k+1];
                in_b = vb[k+1];
                cin  = vc[k+1];
            end else begin
                start = 1'b0;
            end
        end
        @(negedge sys_clk);
    endtask

    task automatic test_reset_mid;
        int dones;
        in_a  = 8'hFF;
        in_b  = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (4) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid immediate: busy=%b done=%b sum=%h cout=%b, need 0 0 00 0",
                     busy, done, sum, cout);
        end else
            $display("reset_mid: outputs cleared immediately");
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge sys_clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL reset_mid aborted_done: active_cycles=%0d, need 0", dones);
        end
        do_add(8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, "after_reset");
    endtask

    task automatic test_random8;
        logic [7:0] a, b;
        logic       ci;
        logic [8:0] exp;
        int         k;
        int         errs;
        errs = 0;
        for (int n = 0; n < 1000; n++) begin
            a   = 8'($urandom);
            b   = 8'($urandom);
            ci  = 1'($urandom_range(0, 1));
            exp = {1'b0, a} + {1'b0, b} + {8'b0, ci};
            in_a = a; in_b = b; cin = ci; start = 1'b1;
            @(negedge sys_clk);
            start = 1'b0;
            k = 0;
            while (done !== 1'b1 && k < 20) begin
                @(negedge sys_clk);
                k++;
            end
            total++;
            if (k >= 20 || {cout, sum} !== exp) begin
                bad++;
                errs++;
                $display("FAIL rand8 #%0d: %h+%h+%b got %b_%h need %h (wait=%0d)",
                         n, a, b, ci, cout, sum, exp, k);
            end
            @(negedge sys_clk);
        end
        $display("rand8: 1000 vectors, %0d wrong", errs);
    endtask

    task automatic test_random13;
        logic [12:0] a, b;
        logic        ci;
        logic [13:0] exp;
        int          k;
        int          errs;
        errs = 0;
        for (int n = 0; n < 1000; n++) begin
            a   = 13'($urandom);
            b   = 13'($urandom);
            ci  = 1'($urandom_range(0, 1));
            exp = {1'b0, a} + {1'b0, b} + {13'b0, ci};
            in_a13 = a; in_b13 = b; cin13 = ci; start13 = 1'b1;
            @(negedge sys_clk);
            start13 = 1'b0;
            k = 0;
            while (done13 !== 1'b1 && k < 30) begin
                @(negedge sys_clk);
                k++;
            end
            total++;
            if (k != 13 || {cout13, sum13} !== exp) begin
                bad++;
                errs++;
                $display("FAIL rand13 #%0d: %h+%h+%b got %b_%h need %h (wait=%0d need 13)",
                         n, a, b, ci, cout13, sum13, exp, k);
            end
            @(negedge sys_clk);
        end
        $display("rand13: 1000 vectors, %0d wrong", errs);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random8();
        test_random13();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
